// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences PC, IR, memory,
// register file and ALU selects from the opcode and a single memory-ready handshake.
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q, state_d;
  logic   op_illegal;

  // Opcode is only meaningful in DECODE; elsewhere the flag is masked below.
  always_comb begin
    op_illegal = 1'b0;
    unique case (opcode)
      OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ: op_illegal = 1'b0;
      default:                                 op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  logic pc_write_raw, branch_raw, mem_write_raw, ir_write_raw, reg_write_raw;
  logic instr_done_raw, illegal_raw;

  always_comb begin
    pc_write_raw   = 1'b0;
    branch_raw     = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    illegal_raw    = 1'b0;
    iord           = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    pc_src         = 2'b00;
    alu_op         = 2'b00;
    case (state_q)
      StFetch: begin
        alu_src_b    = 2'b01;
        alu_op       = 2'b00;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      StDecode: begin
        alu_src_b   = 2'b11;
        illegal_raw = op_illegal;
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        mem_to_reg     = 1'b1;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      StMemWr: begin
        iord           = 1'b1;
        mem_write_raw  = 1'b1;
        instr_done_raw = mem_ready;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_dst        = 1'b1;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      StBranch: begin
        alu_src_a      = 1'b1;
        alu_op         = 2'b01;
        pc_src         = 2'b01;
        branch_raw     = 1'b1;
        instr_done_raw = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      StJump: begin
        pc_src         = 2'b10;
        pc_write_raw   = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every side effect immediately, even mid-instruction.
  assign pc_write   = pc_write_raw & ~rst;
  assign branch     = branch_raw & ~rst;
  assign mem_write  = mem_write_raw & ~rst;
  assign ir_write   = ir_write_raw & ~rst;
  assign reg_write  = reg_write_raw & ~rst;
  assign instr_done = instr_done_raw & ~rst;
  assign illegal_op = illegal_raw & ~rst;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  localparam logic [3:0] F = 0, D = 1, MA = 2, MR = 3, MW = 4, MWR = 5, EX = 6, AW = 7;
  localparam logic [3:0] BR = 8, AE = 9, AWB = 10, JP = 11;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [16:0] vec;
    int          done_exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   step_idx = 0;

  // Output vector order:
  // pc_write branch iord mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a
  // alu_src_b[2] pc_src[2] alu_op[2] instr_done illegal_op
  function automatic logic [16:0] exp_vec(input logic [3:0] st, input logic mr,
                                          input logic r, input logic ill);
    logic pcw, br, io, mwr, irw, rd, m2r, rw, sa, dn, il;
    logic [1:0] sb, ps, ao;
    {pcw, br, io, mwr, irw, rd, m2r, rw, sa, dn, il} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      F:   begin sb = 2'b01; irw = mr; pcw = mr; end
      D:   begin sb = 2'b11; il = ill; end
      MA:  begin sa = 1; sb = 2'b10; end
      MR:  io = 1;
      MW:  begin m2r = 1; rw = 1; dn = 1; end
      MWR: begin io = 1; mwr = 1; dn = mr; end
      EX:  begin sa = 1; ao = 2'b10; end
      AW:  begin rd = 1; rw = 1; dn = 1; end
      BR:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; dn = 1; end
      AE:  begin sa = 1; sb = 2'b10; end
      AWB: begin rw = 1; dn = 1; end
      JP:  begin ps = 2'b10; pcw = 1; dn = 1; end
      default: ;
    endcase
    if (r) {pcw, br, mwr, irw, rw, dn, il} = '0;
    return {pcw, br, io, mwr, irw, rd, m2r, rw, sa, sb, ps, ao, dn, il};
  endfunction

  // One clock cycle of stimulus; st is the state the DUT must be in during this cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic ill, input int done_exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = mr;
    step_idx++;
    e.idx = step_idx; e.st = st; e.vec = exp_vec(st, mr, r, ill); e.done_exp = done_exp;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [16:0] act;
      e = q.pop_front();
      act = {pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, pc_src, alu_op, instr_done, illegal_op};
      if (instr_done) done_cnt++;
      tests++;
      if (state !== e.st) begin
        fails++;
        $display("FAIL state step %0d: got %0d expected %0d", e.idx, state, e.st);
      end
      tests++;
      if (act !== e.vec) begin
        fails++;
        $display("FAIL outputs step %0d (state %0d): got %b expected %b",
                 e.idx, e.st, act, e.vec);
      end
      if (e.done_exp >= 0) begin
        tests++;
        if (done_cnt != e.done_exp) begin
          fails++;
          $display("FAIL done_count step %0d: got %0d expected %0d",
                   e.idx, done_cnt, e.done_exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    // Start an R-type, then reset mid-instruction (in ALUWB) for two cycles.
    step(0, 6'b000000, 1, F,  0, -1);
    step(0, 6'b000000, 1, D,  0, -1);
    step(0, 6'b000000, 1, EX, 0, -1);
    step(1, 6'b000000, 1, AW, 0, -1);
    step(1, 6'b000000, 1, F,  0, -1);
    step(0, 6'b000000, 1, F,  0, 0);
    // R-type then addi back to back.
    step(0, 6'b000000, 1, D,   0, -1);
    step(0, 6'b000000, 1, EX,  0, -1);
    step(0, 6'b000000, 1, AW,  0, -1);
    step(0, 6'b001000, 1, F,   0, -1);
    step(0, 6'b001000, 1, D,   0, -1);
    step(0, 6'b001000, 1, AE,  0, -1);
    step(0, 6'b001000, 1, AWB, 0, 2);
    // lw: 3 FETCH waits, 2 MEMRD waits, 10 cycles total.
    step(0, 6'b100011, 0, F,  0, -1);
    step(0, 6'b100011, 0, F,  0, -1);
    step(0, 6'b100011, 0, F,  0, -1);
    step(0, 6'b100011, 1, F,  0, -1);
    step(0, 6'b100011, 1, D,  0, -1);
    step(0, 6'b100011, 1, MA, 0, -1);
    step(0, 6'b100011, 0, MR, 0, -1);
    step(0, 6'b100011, 0, MR, 0, -1);
    step(0, 6'b100011, 1, MR, 0, -1);
    step(0, 6'b100011, 1, MW, 0, 3);
    // sw
    step(0, 6'b101011, 1, F,   0, -1);
    step(0, 6'b101011, 1, D,   0, -1);
    step(0, 6'b101011, 1, MA,  0, -1);
    step(0, 6'b101011, 1, MWR, 0, 4);
    // beq
    step(0, 6'b000100, 1, F,  0, -1);
    step(0, 6'b000100, 1, D,  0, -1);
    step(0, 6'b000100, 1, BR, 0, 5);
    // j
    step(0, 6'b000010, 1, F,  0, -1);
    step(0, 6'b000010, 1, D,  0, -1);
    step(0, 6'b000010, 1, JP, 0, 6);
    // Illegal opcode
    step(0, 6'b111111, 1, F, 0, -1);
    step(0, 6'b111111, 1, D, 1, -1);
    // sw stalled in MEMWR, then reset while waiting.
    step(0, 6'b101011, 1, F,   0, 6);
    step(0, 6'b101011, 1, D,   0, -1);
    step(0, 6'b101011, 1, MA,  0, -1);
    step(0, 6'b101011, 0, MWR, 0, -1);
    step(1, 6'b101011, 0, MWR, 0, -1);
    step(0, 6'b000010, 1, F,   0, 6);
    step(0, 6'b000010, 1, D,   0, -1);
    step(0, 6'b000010, 1, JP,  0, 7);
    step(0, 6'b000000, 0, F,   0, 7);
    begin
      int budget = 20;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() > 0) begin
        tests++;
        fails++;
        $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
